// File: rtl/switch_voq_ingress.sv
// Per-input-port VOQ stage: steers whole AXI-Stream frames into RADIX per-output FIFOs.
// Define SWITCH_VOQ_MCAST_EN to replicate multi-hot frames instead of dropping them.
module switch_voq_ingress #(
    parameter int unsigned AXIS_DATA_WIDTH  = 64,
    parameter int unsigned AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
    parameter bit          AXIS_ID_ENABLE   = 1'b1,
    parameter int unsigned AXIS_ID_WIDTH    = 8,
    parameter bit          AXIS_USER_ENABLE = 1'b1,
    parameter int unsigned AXIS_USER_WIDTH  = 17,
    parameter int unsigned RADIX            = 4,
    parameter int unsigned AXIS_DEST_WIDTH  = RADIX,
    parameter int unsigned VOQ_DEPTH        = 4096,
    parameter int unsigned COUNT_WIDTH      = $clog2(VOQ_DEPTH / AXIS_KEEP_WIDTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic [AXIS_DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    input  logic [AXIS_ID_WIDTH-1:0]           s_axis_tid,
    input  logic [AXIS_DEST_WIDTH-1:0]         s_axis_tdest,
    input  logic [AXIS_USER_WIDTH-1:0]         s_axis_tuser,

    output logic [RADIX*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [RADIX*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [RADIX-1:0]                   m_axis_tvalid,
    input  logic [RADIX-1:0]                   m_axis_tready,
    output logic [RADIX-1:0]                   m_axis_tlast,
    output logic [RADIX*AXIS_ID_WIDTH-1:0]     m_axis_tid,
    output logic [RADIX*AXIS_DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [RADIX*AXIS_USER_WIDTH-1:0]   m_axis_tuser,

    output logic [RADIX*COUNT_WIDTH-1:0]       m_voq_frame_count,
    output logic                               status_drop_frame
);

    localparam int unsigned Words   = VOQ_DEPTH / AXIS_KEEP_WIDTH;
    localparam int unsigned PtrW    = (Words > 1) ? $clog2(Words) : 1;
    localparam int unsigned OccW    = $clog2(Words + 1);
    localparam int unsigned KeepLsb = AXIS_DATA_WIDTH;
    localparam int unsigned LastBit = KeepLsb + AXIS_KEEP_WIDTH;
    localparam int unsigned IdLsb   = LastBit + 1;
    localparam int unsigned UserLsb = IdLsb + AXIS_ID_WIDTH;
    localparam int unsigned DestLsb = UserLsb + AXIS_USER_WIDTH;
    localparam int unsigned WordW   = DestLsb + AXIS_DEST_WIDTH;

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

    state_e             state_q, state_d;
    logic [RADIX-1:0]   dest_q, dest_d;
    logic [RADIX-1:0]   tdest_mask, mask, voq_rdy, wr_en;
    logic               first_legal, fwd, drop_beat, all_rdy, accept;
    logic [WordW-1:0]   in_word;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Words - 1) ? '0 : p + 1'b1;
    endfunction

    assign tdest_mask = RADIX'(s_axis_tdest);

`ifdef SWITCH_VOQ_MCAST_EN
    assign first_legal = |tdest_mask;
    // Multicast moves only when every selected VOQ can take the beat.
    assign all_rdy     = &(voq_rdy | ~mask);
`else
    logic dest_onehot;
    assign dest_onehot = (|tdest_mask) && ((tdest_mask & (tdest_mask - 1'b1)) == '0);
    assign first_legal = dest_onehot;
    assign all_rdy     = |(voq_rdy & mask);
`endif

    always_comb begin
        mask      = dest_q;
        fwd       = 1'b0;
        drop_beat = 1'b0;
        unique case (state_q)
            StIdle: begin
                mask      = tdest_mask;
                fwd       = first_legal;
                drop_beat = ~first_legal;
            end
            StFwd:   fwd = 1'b1;
            StDrop:  drop_beat = 1'b1;
            default: ;
        endcase
    end

    assign s_axis_tready     = ~rst & (drop_beat | (fwd & all_rdy));
    assign accept            = s_axis_tvalid & s_axis_tready;
    assign wr_en             = (accept & fwd) ? mask : '0;
    assign status_drop_frame = accept & (state_q == StIdle) & ~first_legal;
    assign in_word = {AXIS_DEST_WIDTH'(mask), s_axis_tuser, s_axis_tid, s_axis_tlast,
                      s_axis_tkeep, s_axis_tdata};

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (first_legal) dest_d = mask;
                    if (!s_axis_tlast) state_d = first_legal ? StFwd : StDrop;
                end
                default: if (s_axis_tlast) state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    for (genvar i = 0; i < RADIX; i++) begin : g_voq
        logic [WordW-1:0]       mem_q [Words];
        logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [OccW-1:0]        mem_cnt_q, mem_cnt_d;
        logic                   out_vld_q, out_vld_d;
        logic [WordW-1:0]       out_q, out_d;
        logic [COUNT_WIDTH-1:0] frm_cnt_q, frm_cnt_d;
        logic                   pop, load, full, frm_inc, frm_dec;

        // Occupancy spans the RAM and the output register together.
        assign full       = (32'(mem_cnt_q) + 32'(out_vld_q)) == Words;
        assign pop        = out_vld_q & m_axis_tready[i];
        assign load       = (mem_cnt_q != '0) & (~out_vld_q | pop);
        assign voq_rdy[i] = ~full | pop;
        assign frm_inc    = wr_en[i] & s_axis_tlast;
        assign frm_dec    = pop & out_q[LastBit];

        always_comb begin
            wr_ptr_d  = wr_en[i] ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d  = load ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            out_d     = load ? mem_q[rd_ptr_q] : out_q;
            out_vld_d = load | (out_vld_q & ~pop);
            mem_cnt_d = mem_cnt_q;
            if (wr_en[i] && !load) mem_cnt_d = mem_cnt_q + 1'b1;
            else if (!wr_en[i] && load) mem_cnt_d = mem_cnt_q - 1'b1;
            frm_cnt_d = frm_cnt_q;
            if (frm_inc && !frm_dec) frm_cnt_d = frm_cnt_q + 1'b1;
            else if (!frm_inc && frm_dec) frm_cnt_d = frm_cnt_q - 1'b1;
        end

        always_ff @(posedge clk) begin
            if (wr_en[i]) mem_q[wr_ptr_q] <= in_word;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                mem_cnt_q <= '0;
                out_vld_q <= 1'b0;
                out_q     <= '0;
                frm_cnt_q <= '0;
            end else begin
                wr_ptr_q  <= wr_ptr_d;
                rd_ptr_q  <= rd_ptr_d;
                mem_cnt_q <= mem_cnt_d;
                out_vld_q <= out_vld_d;
                out_q     <= out_d;
                frm_cnt_q <= frm_cnt_d;
            end
        end

        assign m_axis_tvalid[i] = out_vld_q;
        assign m_axis_tlast[i]  = out_q[LastBit];
        assign m_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = out_q[AXIS_DATA_WIDTH-1:0];
        assign m_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH] = out_q[KeepLsb +: AXIS_KEEP_WIDTH];
        assign m_axis_tid[i*AXIS_ID_WIDTH +: AXIS_ID_WIDTH] =
            AXIS_ID_ENABLE ? out_q[IdLsb +: AXIS_ID_WIDTH] : '0;
        assign m_axis_tuser[i*AXIS_USER_WIDTH +: AXIS_USER_WIDTH] =
            AXIS_USER_ENABLE ? out_q[UserLsb +: AXIS_USER_WIDTH] : '0;
        assign m_axis_tdest[i*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH] = out_q[DestLsb +: AXIS_DEST_WIDTH];
        assign m_voq_frame_count[i*COUNT_WIDTH +: COUNT_WIDTH]    = frm_cnt_q;
    end

endmodule
